cpu_run_controller: RTL and testbench
=====================================

// Module: cpu_run_controller
// PURPOSE
//  Run/halt/single-step sequencer for the 16-bit Computer. Produces cpu_en, a clock
//  enable gating PC counter, A/D/*A register writes and RAM store. Halts on debug
//  command, PC breakpoint, jump-to-self (program end) or cycle watchdog. Keeps an
//  executed-instruction count. Sits between the debug/testbench interface and the
//  Computer datapath.
// PARAMETERS
//  W             16  datapath/address width (PC, A, instruction)
//  CNT_W         32  width of executed-instruction counter
//  MAX_CYCLES     0  watchdog limit in executed instructions; 0 = watchdog disabled
//  RUN_ON_RESET   1  1: enter RUN after reset; 0: enter HALT
// PORTS
//  clk          in   1      system clock (same clock as processor and counter)
//  rst          in   1      asynchronous, active-high reset
//  cmd_run      in   1      level-sampled pulse: resume free running
//  cmd_step     in   1      pulse: execute exactly one instruction
//  cmd_halt     in   1      pulse: stop after current cycle
//  bp_en        in   1      breakpoint enable
//  bp_addr      in   W      breakpoint PC value
//  pc           in   W      current PC (ROM address)
//  a_reg        in   W      current A register (jump target)
//  j            in   1      jump-taken from control unit
//  cpu_en       out  1      datapath clock enable (combinational from state + inputs)
//  halted       out  1      1 while state == HALT
//  step_done    out  1      one-cycle pulse, cycle after a STEP instruction executes
//  halt_reason  out  2      0 CMD/reset, 1 BREAK, 2 LOOP, 3 WDOG; held until next run/step
//  instr_count  out  CNT_W  instructions executed since reset
// BEHAVIOUR
//  - Reset (async, rst=1): state = RUN if RUN_ON_RESET else HALT; instr_count=0;
//    halt_reason=0; step_done=0; skip_bp=1. Release is synchronous to clk.
//  - States (2-bit): HALT, RUN, STEP.
//    HALT: cpu_en=0. cmd_halt > cmd_step > cmd_run priority when simultaneous.
//      cmd_step -> STEP; cmd_run -> RUN with skip_bp=1; halt_reason cleared to 0.
//    RUN: cpu_en = !bp_hit. Next state HALT if cmd_halt (reason CMD), bp_hit (BREAK),
//      loop_hit (LOOP) or wdog_hit (WDOG); priority BREAK > LOOP > WDOG > CMD.
//      cmd_run/cmd_step ignored in RUN.
//    STEP: cpu_en=1 for exactly one cycle, breakpoint ignored; next state HALT,
//      step_done=1 next cycle. loop_hit/wdog_hit still update halt_reason.
//  - bp_hit = bp_en && pc==bp_addr && !skip_bp. Evaluated before execution: the
//    instruction at bp_addr is NOT executed (cpu_en low that cycle). skip_bp is
//    set on entry to RUN, cleared after first RUN cycle with cpu_en=1, so resuming
//    from a breakpoint executes that instruction.
//  - loop_hit = cpu_en && j && a_reg==pc: instruction executes (harmless
//    self-jump), then HALT next cycle.
//  - wdog_hit = MAX_CYCLES!=0 && cpu_en && instr_count==MAX_CYCLES-1: halt after the
//    MAX_CYCLES-th instruction.
//  - instr_count increments on every cycle with cpu_en=1; saturates at all-ones
//    (no wrap). Unsigned compare only.
//  - cmd_* sampled every clk edge; a pulse longer than one cycle is treated as
//    repeated commands (cmd_step held = repeated steps with one HALT cycle between).
//  - Reset mid-RUN/STEP: immediate return to reset state; no step_done pulse.
// STRUCTURE
//  - Shared package/header (cpu_debug_defs.vh): state encodings S_HALT/S_RUN/S_STEP,
//    halt-reason codes HR_CMD/HR_BREAK/HR_LOOP/HR_WDOG.
//  - One sub-module: sat_counter (CNT_W, en, async rst, saturating) for instr_count.
//  - Integration: Computer gates counter/processor writes with cpu_en.
// TESTING
//  - Reset, RUN_ON_RESET=1, 5 cycles -> cpu_en=1 each cycle, instr_count=5, halted=0.
//  - bp_en=1, bp_addr=0x0004, straight-line code -> halt with PC=4, instr_count=4,
//    halt_reason=1; cmd_run -> PC 4 executes, continues to 5.
//  - From HALT, cmd_step x3 -> three single cpu_en pulses, step_done each, PC+3.
//  - Program ending "A=7; JMP" at PC 7 -> one execution at PC 7, halted=1, reason=2.
//  - MAX_CYCLES=10, infinite loop body without self-jump -> halt, instr_count=10, reason=3.
//  - cmd_halt+cmd_step same cycle in HALT -> stays HALT, cpu_en=0; rst during STEP
//    -> state reset, step_done stays 0, instr_count=0.

Source files
------------

// File: rtl/cpu_run_controller_pkg.sv
// cpu_run_controller_pkg: sequencer state and halt-reason encodings
package cpu_run_controller_pkg;
  typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP} state_t;
  typedef enum logic [1:0] {HR_CMD, HR_BREAK, HR_LOOP, HR_WDOG} reason_t;
endpackage

// File: rtl/cpu_run_controller_if.sv
// cpu_run_controller_if: debug commands, datapath taps and run-control outputs
interface cpu_run_controller_if #(parameter int W = 16, parameter int CNT_W = 32);
  logic             cmd_run;
  logic             cmd_step;
  logic             cmd_halt;
  logic             bp_en;
  logic [W-1:0]     bp_addr;
  logic [W-1:0]     pc;
  logic [W-1:0]     a_reg;
  logic             j;
  logic             cpu_en;
  logic             halted;
  logic             step_done;
  logic [1:0]       halt_reason;
  logic [CNT_W-1:0] instr_count;
  modport master (
    output cmd_run, cmd_step, cmd_halt, bp_en, bp_addr, pc, a_reg, j,
    input  cpu_en, halted, step_done, halt_reason, instr_count
  );
  modport slave (
    input  cmd_run, cmd_step, cmd_halt, bp_en, bp_addr, pc, a_reg, j,
    output cpu_en, halted, step_done, halt_reason, instr_count
  );
endinterface

// File: rtl/cpu_run_controller_sat_counter.sv
// cpu_run_controller_sat_counter: enable-gated up counter that sticks at all-ones
module cpu_run_controller_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);
  logic [CNT_W-1:0] r_count;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_count <= '0;
    else if (i_en && !(&r_count)) r_count <= r_count + 1'b1;
  assign o_count = r_count;
endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: run/halt/single-step sequencer producing the datapath clock enable
module cpu_run_controller
  import cpu_run_controller_pkg::*;
#(
  parameter int W            = 16,
  parameter int CNT_W        = 32,
  parameter int MAX_CYCLES   = 0,
  parameter bit RUN_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_run_controller_if.slave  bus
);
  state_t           r_state, w_next;
  reason_t          r_reason, w_reason;
  logic             r_skip_bp, w_skip_bp;
  logic             r_step_done;
  logic             w_bp_hit, w_loop_hit, w_wdog_hit, w_cpu_en;
  logic [CNT_W-1:0] w_count;
  assign w_bp_hit   = r_state == S_RUN && bus.bp_en && bus.pc == W'(bus.bp_addr) && !r_skip_bp;
  assign w_cpu_en   = (r_state == S_RUN && !w_bp_hit) || r_state == S_STEP;
  assign w_loop_hit = w_cpu_en && bus.j && bus.a_reg == bus.pc;
  assign w_wdog_hit = MAX_CYCLES != 0 && w_cpu_en && w_count == CNT_W'(MAX_CYCLES - 1);
  always_comb begin
    w_next    = r_state;
    w_reason  = r_reason;
    w_skip_bp = r_skip_bp;
    case (r_state)
      S_HALT:
        if (bus.cmd_halt) w_next = S_HALT;
        else if (bus.cmd_step) begin
          w_next   = S_STEP;
          w_reason = HR_CMD;
        end else if (bus.cmd_run) begin
          w_next    = S_RUN;
          w_reason  = HR_CMD;
          w_skip_bp = 1'b1;
        end
      S_RUN: begin
        w_skip_bp = w_cpu_en ? 1'b0 : r_skip_bp;
        if (w_bp_hit || w_loop_hit || w_wdog_hit || bus.cmd_halt) begin
          w_next   = S_HALT;
          w_reason = w_bp_hit ? HR_BREAK : w_loop_hit ? HR_LOOP : w_wdog_hit ? HR_WDOG : HR_CMD;
        end
      end
      S_STEP: begin
        w_next   = S_HALT;
        w_reason = w_loop_hit ? HR_LOOP : w_wdog_hit ? HR_WDOG : r_reason;
      end
      default: w_next = S_HALT;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= RUN_ON_RESET ? S_RUN : S_HALT;
      r_reason    <= HR_CMD;
      r_skip_bp   <= 1'b1;
      r_step_done <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_reason    <= w_reason;
      r_skip_bp   <= w_skip_bp;
      r_step_done <= r_state == S_STEP;
    end
  cpu_run_controller_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_cpu_en),
    .o_count (w_count)
  );
  assign bus.cpu_en      = w_cpu_en;
  assign bus.halted      = r_state == S_HALT;
  assign bus.step_done   = r_step_done;
  assign bus.halt_reason = r_reason;
  assign bus.instr_count = w_count;
endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: directed checks of run, breakpoint, step, loop, watchdog and reset
module tb_cpu_run_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loop_en = 1'b0;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  cpu_run_controller_if #(.W(16), .CNT_W(32)) b0 ();
  cpu_run_controller_if #(.W(16), .CNT_W(32)) b1 ();
  cpu_run_controller #(.W(16), .CNT_W(32), .MAX_CYCLES(0), .RUN_ON_RESET(1'b1)) dut0 (
    .clk (clk), .rst (rst), .bus (b0.slave));
  cpu_run_controller #(.W(16), .CNT_W(32), .MAX_CYCLES(10), .RUN_ON_RESET(1'b0)) dut1 (
    .clk (clk), .rst (rst), .bus (b1.slave));
  assign b0.a_reg = 16'd7;
  assign b0.j     = loop_en && b0.pc == 16'd7;
  assign b1.a_reg = 16'd0;
  assign b1.j     = 1'b0;
  always @(posedge clk or posedge rst)
    if (rst) b0.pc <= '0;
    else if (b0.cpu_en) b0.pc <= b0.j ? b0.a_reg : b0.pc + 16'd1;
  always @(posedge clk or posedge rst)
    if (rst) b1.pc <= '0;
    else if (b1.cpu_en) b1.pc <= b1.pc + 16'd1;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_halted", b0.halted, 0);
    chk("rst_count", b0.instr_count, 0);
    chk("rst_reason", b0.halt_reason, 0);
    chk("rst_step_done", b0.step_done, 0);
    chk("rst_halted_dut1", b1.halted, 1);
    chk("rst_cpu_en_dut1", b1.cpu_en, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("run_cpu_en", b0.cpu_en, 1);
      tick();
    end
    chk("run_count", b0.instr_count, 5);
    chk("run_pc", b0.pc, 5);
    chk("run_halted", b0.halted, 0);
  endtask
  task automatic test_breakpoint();
    b0.bp_en   = 1'b1;
    b0.bp_addr = 16'd4;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20 && !b0.halted; i++) tick();
    chk("bp_halted", b0.halted, 1);
    chk("bp_pc", b0.pc, 4);
    chk("bp_count", b0.instr_count, 4);
    chk("bp_reason", b0.halt_reason, 1);
    chk("bp_cpu_en_off", b0.cpu_en, 0);
    b0.cmd_run = 1'b1;
    tick();
    b0.cmd_run = 1'b0;
    chk("resume_halted", b0.halted, 0);
    chk("resume_reason", b0.halt_reason, 0);
    chk("resume_cpu_en", b0.cpu_en, 1);
    tick();
    chk("resume_pc", b0.pc, 5);
    chk("resume_count", b0.instr_count, 5);
    b0.cmd_halt = 1'b1;
    tick();
    b0.cmd_halt = 1'b0;
    b0.bp_en    = 1'b0;
    chk("cmd_halt_halted", b0.halted, 1);
    chk("cmd_halt_reason", b0.halt_reason, 0);
    chk("cmd_halt_pc", b0.pc, 6);
    tick();
    chk("halt_hold_pc", b0.pc, 6);
    chk("halt_hold_cpu_en", b0.cpu_en, 0);
  endtask
  task automatic test_step();
    for (int k = 0; k < 3; k++) begin
      b0.cmd_step = 1'b1;
      tick();
      b0.cmd_step = 1'b0;
      chk("step_cpu_en", b0.cpu_en, 1);
      chk("step_not_done", b0.step_done, 0);
      tick();
      chk("step_done", b0.step_done, 1);
      chk("step_halted", b0.halted, 1);
      chk("step_cpu_en_off", b0.cpu_en, 0);
      tick();
      chk("step_done_pulse", b0.step_done, 0);
    end
    chk("step_pc", b0.pc, 9);
    chk("step_count", b0.instr_count, 9);
  endtask
  task automatic test_halt_step_same();
    b0.cmd_halt = 1'b1;
    b0.cmd_step = 1'b1;
    tick();
    b0.cmd_halt = 1'b0;
    b0.cmd_step = 1'b0;
    chk("prio_halted", b0.halted, 1);
    chk("prio_cpu_en", b0.cpu_en, 0);
    tick();
    chk("prio_pc", b0.pc, 9);
    chk("prio_step_done", b0.step_done, 0);
  endtask
  task automatic test_loop();
    loop_en = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20 && !b0.halted; i++) tick();
    chk("loop_halted", b0.halted, 1);
    chk("loop_pc", b0.pc, 7);
    chk("loop_count", b0.instr_count, 8);
    chk("loop_reason", b0.halt_reason, 2);
    loop_en = 1'b0;
  endtask
  task automatic test_step_reset();
    b0.cmd_step = 1'b1;
    tick();
    b0.cmd_step = 1'b0;
    chk("sr_in_step", b0.cpu_en, 1);
    rst = 1'b1;
    #1;
    chk("sr_halted", b0.halted, 0);
    chk("sr_count", b0.instr_count, 0);
    chk("sr_reason", b0.halt_reason, 0);
    tick();
    chk("sr_step_done", b0.step_done, 0);
    chk("sr_count_hold", b0.instr_count, 0);
    rst = 1'b0;
  endtask
  task automatic test_watchdog();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("wd_start_halted", b1.halted, 1);
    b1.cmd_run = 1'b1;
    tick();
    b1.cmd_run = 1'b0;
    chk("wd_running", b1.halted, 0);
    for (int i = 0; i < 30 && !b1.halted; i++) tick();
    chk("wd_halted", b1.halted, 1);
    chk("wd_count", b1.instr_count, 10);
    chk("wd_reason", b1.halt_reason, 3);
    chk("wd_pc", b1.pc, 10);
  endtask
  initial begin
    {b0.cmd_run, b0.cmd_step, b0.cmd_halt, b0.bp_en} = '0;
    {b1.cmd_run, b1.cmd_step, b1.cmd_halt, b1.bp_en} = '0;
    b0.bp_addr = '0;
    b1.bp_addr = '0;
    test_reset();
    test_breakpoint();
    test_step();
    test_halt_step_same();
    test_loop();
    test_step_reset();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
